// File: rtl/fmac_arbiter.sv
// fmac_arbiter
// Shares one pipelined, fixed-latency FMAC between NREQ requesters.
// Requests are granted round-robin, at most one per cycle. Each issued
// operation carries its requester index down a tag pipe that runs alongside
// the FMAC, so the result can be routed back to the requester that issued it.
// A drain handshake lets a controller empty the FMAC before reconfiguring it.
// Optional busy/stall statistics counters: define FMAC_ARBITER_STATS_EN.
module fmac_arbiter #(
    parameter int NREQ       = 4,
    parameter int FMAC_DELAY = 8,
    parameter int MAX_OUT    = 8
) (
    input  logic                clk,
    input  logic                rst,
`ifdef FMAC_ARBITER_STATS_EN
    input  logic                stat_clr,
    output logic [31:0]         stat_busy,
    output logic [31:0]         stat_stall,
`endif
    input  logic [NREQ*32-1:0]  REQ_A_TDATA,
    input  logic [NREQ*32-1:0]  REQ_B_TDATA,
    input  logic [NREQ*32-1:0]  REQ_C_TDATA,
    input  logic [NREQ-1:0]     REQ_TVALID,
    output logic [NREQ-1:0]     REQ_TREADY,
    output logic [31:0]         RSP_TDATA,
    output logic [NREQ-1:0]     RSP_TVALID,
    output logic [31:0]         FMAC_A_TDATA,
    output logic [31:0]         FMAC_B_TDATA,
    output logic [31:0]         FMAC_C_TDATA,
    output logic                FMAC_TVALID,
    input  logic [31:0]         FMAC_OUT_TDATA,
    input  logic                FMAC_OUT_TVALID,
    input  logic                drain_req,
    output logic                drained,
    output logic                tag_err
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SUMW = IDXW + 1;
    localparam int CNTW = $clog2(MAX_OUT + 1);
    localparam logic [CNTW-1:0] MAX_OUT_C = CNTW'(MAX_OUT);
    localparam logic [SUMW-1:0] NREQ_C    = SUMW'(NREQ);
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DRAINED = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [IDXW-1:0] rr_ptr;
    logic [CNTW-1:0] cnt [NREQ];
    logic [NREQ-1:0] eligible;

    logic            grant_any;
    logic [IDXW-1:0] grant_idx;
    logic [SUMW-1:0] cand_sum;
    logic [IDXW-1:0] cand_idx;

    logic [31:0]     sel_a;
    logic [31:0]     sel_b;
    logic [31:0]     sel_c;

    logic            issue_valid;
    logic [IDXW-1:0] issue_idx;

    logic            tag_v   [FMAC_DELAY];
    logic [IDXW-1:0] tag_idx [FMAC_DELAY];
    logic            tags_empty;
    logic            rsp_hit;

    // A requester may be granted only while running, not being asked to
    // drain, not in reset, and with room left in its outstanding budget.
    always_comb begin
        eligible = '0;
        for (int k = 0; k < NREQ; k++) begin
            eligible[k] = REQ_TVALID[k] && (cnt[k] < MAX_OUT_C) &&
                          (state == ST_RUN) && !drain_req && !rst;
        end
    end

    // Round-robin search: first eligible requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand_sum  = '0;
        cand_idx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_sum = {1'b0, rr_ptr} + SUMW'(i);
            if (cand_sum >= NREQ_C) begin
                cand_sum = cand_sum - NREQ_C;
            end
            cand_idx = cand_sum[IDXW-1:0];
            if (!grant_any && eligible[cand_idx]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    // One-hot accept strobe and operand mux for the granted requester.
    always_comb begin
        REQ_TREADY = '0;
        sel_a      = '0;
        sel_b      = '0;
        sel_c      = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_any && (grant_idx == IDXW'(k))) begin
                REQ_TREADY[k] = 1'b1;
                sel_a         = REQ_A_TDATA[k*32 +: 32];
                sel_b         = REQ_B_TDATA[k*32 +: 32];
                sel_c         = REQ_C_TDATA[k*32 +: 32];
            end
        end
    end

    // Pointer moves just past the last winner; it holds when nobody wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        end
    end

    // Registered issue stage: operands are held when nothing is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid  <= 1'b0;
            issue_idx    <= '0;
            FMAC_A_TDATA <= '0;
            FMAC_B_TDATA <= '0;
            FMAC_C_TDATA <= '0;
        end else begin
            issue_valid <= grant_any;
            if (grant_any) begin
                issue_idx    <= grant_idx;
                FMAC_A_TDATA <= sel_a;
                FMAC_B_TDATA <= sel_b;
                FMAC_C_TDATA <= sel_c;
            end
        end
    end

    assign FMAC_TVALID = issue_valid;

    // Tag pipe shadows the FMAC so its tail lines up with FMAC_OUT_TVALID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FMAC_DELAY; i++) begin
                tag_v[i]   <= 1'b0;
                tag_idx[i] <= '0;
            end
        end else begin
            tag_v[0]   <= issue_valid;
            tag_idx[0] <= issue_idx;
            for (int i = 1; i < FMAC_DELAY; i++) begin
                tag_v[i]   <= tag_v[i-1];
                tag_idx[i] <= tag_idx[i-1];
            end
        end
    end

    // Pipeline is empty once no tag entry is valid.
    always_comb begin
        tags_empty = 1'b1;
        for (int i = 0; i < FMAC_DELAY; i++) begin
            if (tag_v[i]) begin
                tags_empty = 1'b0;
            end
        end
    end

    // Route the FMAC result to the requester named by the tail tag.
    always_comb begin
        RSP_TVALID = '0;
        rsp_hit    = FMAC_OUT_TVALID && tag_v[FMAC_DELAY-1];
        for (int k = 0; k < NREQ; k++) begin
            if (rsp_hit && (tag_idx[FMAC_DELAY-1] == IDXW'(k))) begin
                RSP_TVALID[k] = 1'b1;
            end
        end
    end

    assign RSP_TDATA = FMAC_OUT_TDATA;

    // A result with no tag behind it is dropped and flagged until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_err <= 1'b0;
        end else if (FMAC_OUT_TVALID && !tag_v[FMAC_DELAY-1]) begin
            tag_err <= 1'b1;
        end
    end

    // Outstanding ops per requester: up on grant, down on response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREQ; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (REQ_TREADY[k] && !RSP_TVALID[k]) begin
                    cnt[k] <= cnt[k] + 1'b1;
                end else if (RSP_TVALID[k] && !REQ_TREADY[k]) begin
                    cnt[k] <= cnt[k] - 1'b1;
                end
            end
        end
    end

    // Drain state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Drain sequencing: stop granting, wait for the pipe to empty, then
    // hold in ST_DRAINED until the controller lets go of drain_req.
    always_comb begin
        state_next = state;
        drained    = 1'b0;
        case (state)
            ST_RUN: begin
                if (drain_req) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!issue_valid && tags_empty) begin
                    state_next = ST_DRAINED;
                end
            end
            ST_DRAINED: begin
                drained = 1'b1;
                if (!drain_req) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

`ifdef FMAC_ARBITER_STATS_EN
    // Saturating busy/stall counters; a synchronous clear beats an increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_busy  <= '0;
            stat_stall <= '0;
        end else if (stat_clr) begin
            stat_busy  <= '0;
            stat_stall <= '0;
        end else begin
            if (issue_valid && (stat_busy != 32'hFFFF_FFFF)) begin
                stat_busy <= stat_busy + 32'd1;
            end
            if ((|REQ_TVALID) && !grant_any && (stat_stall != 32'hFFFF_FFFF)) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fmac_arbiter.sv
// tb_fmac_arbiter
// Self-checking bench for fmac_arbiter. A behavioural FMAC echoes operand A
// after FMAC_DELAY cycles; a scoreboard queue records every handshake and
// checks the routed response, its data and its arrival cycle. A second
// instance with MAX_OUT=2 exercises the outstanding-op limit.
// Stats checks are compiled in when FMAC_ARBITER_STATS_EN is defined.
module tb_fmac_arbiter;

    localparam int NREQ       = 4;
    localparam int FMAC_DELAY = 8;

    logic clk = 1'b0;
    logic rst;

    // Free-running clock.
    always #5 clk = ~clk;

    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ*32-1:0] req_c;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [31:0]        rsp_data;
    logic [NREQ-1:0]    rsp_valid;
    logic [31:0]        fmac_a;
    logic [31:0]        fmac_b;
    logic [31:0]        fmac_c;
    logic               fmac_valid;
    logic [31:0]        fmac_out_data;
    logic               fmac_out_valid;
    logic               drain_req;
    logic               drained;
    logic               tag_err;
    logic               inject;
    logic [31:0]        inject_data;

    logic [NREQ-1:0]    req_valid2;
    logic [NREQ-1:0]    req_ready2;
    logic [31:0]        rsp_data2;
    logic [NREQ-1:0]    rsp_valid2;
    logic [31:0]        fmac2_a;
    logic [31:0]        fmac2_b;
    logic [31:0]        fmac2_c;
    logic               fmac2_valid;
    logic [31:0]        fmac2_out_data;
    logic               fmac2_out_valid;
    logic               drain2 = 1'b0;
    logic               drained2;
    logic               tag_err2;

`ifdef FMAC_ARBITER_STATS_EN
    logic               stat_clr;
    logic [31:0]        stat_busy;
    logic [31:0]        stat_stall;
    logic               stat_clr2 = 1'b0;
    logic [31:0]        stat_busy2;
    logic [31:0]        stat_stall2;
`endif

    fmac_arbiter #(.NREQ(NREQ), .FMAC_DELAY(FMAC_DELAY), .MAX_OUT(8)) dut (
        .clk             (clk),
        .rst             (rst),
`ifdef FMAC_ARBITER_STATS_EN
        .stat_clr        (stat_clr),
        .stat_busy       (stat_busy),
        .stat_stall      (stat_stall),
`endif
        .REQ_A_TDATA     (req_a),
        .REQ_B_TDATA     (req_b),
        .REQ_C_TDATA     (req_c),
        .REQ_TVALID      (req_valid),
        .REQ_TREADY      (req_ready),
        .RSP_TDATA       (rsp_data),
        .RSP_TVALID      (rsp_valid),
        .FMAC_A_TDATA    (fmac_a),
        .FMAC_B_TDATA    (fmac_b),
        .FMAC_C_TDATA    (fmac_c),
        .FMAC_TVALID     (fmac_valid),
        .FMAC_OUT_TDATA  (fmac_out_data),
        .FMAC_OUT_TVALID (fmac_out_valid),
        .drain_req       (drain_req),
        .drained         (drained),
        .tag_err         (tag_err)
    );

    fmac_arbiter #(.NREQ(NREQ), .FMAC_DELAY(FMAC_DELAY), .MAX_OUT(2)) dut2 (
        .clk             (clk),
        .rst             (rst),
`ifdef FMAC_ARBITER_STATS_EN
        .stat_clr        (stat_clr2),
        .stat_busy       (stat_busy2),
        .stat_stall      (stat_stall2),
`endif
        .REQ_A_TDATA     (req_a),
        .REQ_B_TDATA     (req_b),
        .REQ_C_TDATA     (req_c),
        .REQ_TVALID      (req_valid2),
        .REQ_TREADY      (req_ready2),
        .RSP_TDATA       (rsp_data2),
        .RSP_TVALID      (rsp_valid2),
        .FMAC_A_TDATA    (fmac2_a),
        .FMAC_B_TDATA    (fmac2_b),
        .FMAC_C_TDATA    (fmac2_c),
        .FMAC_TVALID     (fmac2_valid),
        .FMAC_OUT_TDATA  (fmac2_out_data),
        .FMAC_OUT_TVALID (fmac2_out_valid),
        .drain_req       (drain2),
        .drained         (drained2),
        .tag_err         (tag_err2)
    );

    // Behavioural FMACs: echo operand A exactly FMAC_DELAY cycles later.
    logic        pipe_v  [FMAC_DELAY];
    logic [31:0] pipe_d  [FMAC_DELAY];
    logic        pipe2_v [FMAC_DELAY];
    logic [31:0] pipe2_d [FMAC_DELAY];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FMAC_DELAY; i++) begin
                pipe_v[i]  <= 1'b0;
                pipe_d[i]  <= '0;
                pipe2_v[i] <= 1'b0;
                pipe2_d[i] <= '0;
            end
        end else begin
            pipe_v[0]  <= fmac_valid;
            pipe_d[0]  <= fmac_a;
            pipe2_v[0] <= fmac2_valid;
            pipe2_d[0] <= fmac2_a;
            for (int i = 1; i < FMAC_DELAY; i++) begin
                pipe_v[i]  <= pipe_v[i-1];
                pipe_d[i]  <= pipe_d[i-1];
                pipe2_v[i] <= pipe2_v[i-1];
                pipe2_d[i] <= pipe2_d[i-1];
            end
        end
    end

    assign fmac_out_valid  = pipe_v[FMAC_DELAY-1] | inject;
    assign fmac_out_data   = inject ? inject_data : pipe_d[FMAC_DELAY-1];
    assign fmac2_out_valid = pipe2_v[FMAC_DELAY-1];
    assign fmac2_out_data  = pipe2_d[FMAC_DELAY-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ-1:0] v2,
                                 input logic drn, input logic inj);
        @(posedge clk);
        #1;
        req_valid   = v;
        req_valid2  = v2;
        drain_req   = drn;
        inject      = inj;
        inject_data = 32'hDEAD_0000 | (cyc & 32'hFFFF);
        for (int k = 0; k < NREQ; k++) begin
            req_a[k*32 +: 32] = {4'hA, 4'(k), 24'(cyc)};
            req_b[k*32 +: 32] = {4'hB, 4'(k), 24'(cyc)};
            req_c[k*32 +: 32] = {4'hC, 4'(k), 24'(cyc)};
        end
    endtask

    // Scoreboard: one entry per handshake on the main instance.
    typedef struct {
        logic [NREQ-1:0] onehot;
        logic [31:0]     data;
        int              due;
    } sb_t;
    sb_t sb_q[$];

    // Monitor: push on handshake, pop and compare on each response.
    always @(negedge clk) begin : monitor
        sb_t e;
        if (!rst) begin
            for (int k = 0; k < NREQ; k++) begin
                if (req_valid[k] && req_ready[k]) begin
                    e.onehot = NREQ'(1) << k;
                    e.data   = req_a[k*32 +: 32];
                    e.due    = cyc + FMAC_DELAY + 1;
                    sb_q.push_back(e);
                end
            end
            if (rsp_valid != '0) begin
                if (sb_q.size() == 0) begin
                    checkOutput("rsp_unexpected", 32'(rsp_valid), 32'h0);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("rsp_idx", 32'(rsp_valid), 32'(e.onehot));
                    checkOutput("rsp_data", rsp_data, e.data);
                    checkOutput("rsp_cycle", cyc, e.due);
                end
            end
        end
    end

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            applyStimulus('0, '0, 1'b0, 1'b0);
            n++;
        end
        checkOutput(name, sb_q.size(), 0);
        repeat (3) applyStimulus('0, '0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic [NREQ-1:0] valid;
        logic [NREQ-1:0] ready;
        logic [NREQ-1:0] rsp;
    } vec_t;

    vec_t            rr_tab [12];
    vec_t            mo_tab [13];
    logic [NREQ-1:0] dr_exp [5];
    logic [NREQ-1:0] acc;

    initial begin
        // Round-robin table from reset (rr_ptr starts at 0).
        rr_tab[0]  = '{4'b1111, 4'b0001, 4'b0000};
        rr_tab[1]  = '{4'b1111, 4'b0010, 4'b0000};
        rr_tab[2]  = '{4'b1111, 4'b0100, 4'b0000};
        rr_tab[3]  = '{4'b1111, 4'b1000, 4'b0000};
        rr_tab[4]  = '{4'b1010, 4'b0010, 4'b0000};
        rr_tab[5]  = '{4'b1010, 4'b1000, 4'b0000};
        rr_tab[6]  = '{4'b0001, 4'b0001, 4'b0000};
        rr_tab[7]  = '{4'b0000, 4'b0000, 4'b0000};
        rr_tab[8]  = '{4'b0001, 4'b0001, 4'b0000};
        rr_tab[9]  = '{4'b0110, 4'b0010, 4'b0000};
        rr_tab[10] = '{4'b0110, 4'b0100, 4'b0000};
        rr_tab[11] = '{4'b0101, 4'b0001, 4'b0000};
        // MAX_OUT=2 instance, requester 2 alone: two issues, stall, resume.
        for (int i = 0; i < 13; i++) begin
            mo_tab[i] = '{4'b0100, 4'b0000, 4'b0000};
        end
        mo_tab[0].ready  = 4'b0100;
        mo_tab[1].ready  = 4'b0100;
        mo_tab[10].ready = 4'b0100;
        mo_tab[11].ready = 4'b0100;
        mo_tab[9].rsp    = 4'b0100;
        mo_tab[10].rsp   = 4'b0100;
        // Grants before the drain, continuing from rr_ptr=1.
        dr_exp[0] = 4'b0010;
        dr_exp[1] = 4'b0100;
        dr_exp[2] = 4'b1000;
        dr_exp[3] = 4'b0001;
        dr_exp[4] = 4'b0010;

        rst         = 1'b1;
        req_valid   = '0;
        req_valid2  = '0;
        drain_req   = 1'b0;
        inject      = 1'b0;
        inject_data = '0;
        req_a       = '0;
        req_b       = '0;
        req_c       = '0;
`ifdef FMAC_ARBITER_STATS_EN
        stat_clr    = 1'b0;
`endif
        #2;
        checkOutput("reset_ready", 32'(req_ready), 32'h0);
        checkOutput("reset_fmac_valid", 32'(fmac_valid), 32'h0);
        checkOutput("reset_fmac_a", fmac_a, 32'h0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("reset_tag_err", 32'(tag_err), 32'h0);
        checkOutput("reset_drained", 32'(drained), 32'h0);
`ifdef FMAC_ARBITER_STATS_EN
        checkOutput("reset_stat_busy", stat_busy, 32'h0);
        checkOutput("reset_stat_stall", stat_stall, 32'h0);
`endif
        #21;
        rst = 1'b0;

        $display("[TB] round-robin table");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(rr_tab[i].valid, '0, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("rr_grant_%0d", i), 32'(req_ready), 32'(rr_tab[i].ready));
        end
        waitIdle("rr_drain_responses");

        $display("[TB] outstanding limit");
        for (int i = 0; i < 13; i++) begin
            applyStimulus('0, mo_tab[i].valid, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("mo_ready_%0d", i), 32'(req_ready2), 32'(mo_tab[i].ready));
            checkOutput($sformatf("mo_rsp_%0d", i), 32'(rsp_valid2), 32'(mo_tab[i].rsp));
        end
        repeat (12) applyStimulus('0, '0, 1'b0, 1'b0);
        checkOutput("mo_tag_err", 32'(tag_err2), 32'h0);

        $display("[TB] drain with five in flight");
        acc = '0;
        for (int i = 0; i < 18; i++) begin
            applyStimulus(4'b1111, '0, (i >= 5 && i <= 15), 1'b0);
            @(negedge clk);
            if (i < 5) begin
                checkOutput($sformatf("drain_pre_grant_%0d", i), 32'(req_ready), 32'(dr_exp[i]));
            end else if (i < 17) begin
                acc = acc | req_ready;
                checkOutput($sformatf("drained_%0d", i), 32'(drained), 32'(i >= 15));
            end else begin
                checkOutput("drain_resume_grant", 32'(req_ready), 32'h4);
                checkOutput("drain_resume_drained", 32'(drained), 32'h0);
            end
        end
        checkOutput("drain_no_grant", 32'(acc), 32'h0);
        waitIdle("drain_responses");

        $display("[TB] tag error injection");
        applyStimulus('0, '0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("inject_no_rsp", 32'(rsp_valid), 32'h0);
        checkOutput("inject_tag_err_before", 32'(tag_err), 32'h0);
        applyStimulus('0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("inject_tag_err_set", 32'(tag_err), 32'h1);
        repeat (5) applyStimulus('0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("inject_tag_err_sticky", 32'(tag_err), 32'h1);

        $display("[TB] asynchronous reset mid-stream");
        repeat (3) applyStimulus(4'b1111, '0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("arst_ready", 32'(req_ready), 32'h0);
        checkOutput("arst_fmac_valid", 32'(fmac_valid), 32'h0);
        checkOutput("arst_fmac_a", fmac_a, 32'h0);
        checkOutput("arst_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("arst_tag_err", 32'(tag_err), 32'h0);
        checkOutput("arst_drained", 32'(drained), 32'h0);
        sb_q.delete();
        req_valid = '0;
        #3;
        rst = 1'b0;
        applyStimulus(4'b1111, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("arst_first_grant", 32'(req_ready), 32'h1);
        repeat (4) applyStimulus(4'b1111, '0, 1'b0, 1'b0);
        applyStimulus('0, '0, 1'b0, 1'b0);
        waitIdle("arst_responses");

`ifdef FMAC_ARBITER_STATS_EN
        $display("[TB] statistics counters");
        applyStimulus('0, '0, 1'b0, 1'b0);
        stat_clr = 1'b1;
        applyStimulus('0, '0, 1'b0, 1'b0);
        stat_clr = 1'b0;
        repeat (10) applyStimulus(4'b1111, '0, 1'b0, 1'b0);
        applyStimulus('0, '0, 1'b0, 1'b0);
        waitIdle("stat_responses");
        applyStimulus(4'b1111, '0, 1'b1, 1'b0);
        applyStimulus(4'b1111, '0, 1'b1, 1'b0);
        applyStimulus(4'b1111, '0, 1'b0, 1'b0);
        applyStimulus('0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("stat_busy", stat_busy, 32'd10);
        checkOutput("stat_stall", stat_stall, 32'd3);
        applyStimulus('0, '0, 1'b0, 1'b0);
        stat_clr = 1'b1;
        applyStimulus('0, '0, 1'b0, 1'b0);
        stat_clr = 1'b0;
        @(negedge clk);
        checkOutput("stat_busy_clr", stat_busy, 32'd0);
        checkOutput("stat_stall_clr", stat_stall, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/fmac_arbiter.md
Name: fmac_arbiter

Overview:
- Shares one pipelined axis_fmac unit (fixed latency, no back-pressure) between NREQ independent requesters, e.g. several dot-product engines.
- Round-robin arbitration; at most one operation issued per cycle.
- Each issue is tagged with the requester index; the result returned FMAC_DELAY cycles later is routed back to that requester.
- Provides a drain handshake so a top-level controller can quiesce the FMAC before reconfiguring weights.

Parameters:
NREQ, 4, number of requesters (2..8)
FMAC_DELAY, 8, cycles from FMAC_TVALID to FMAC_OUT_TVALID
MAX_OUT, 8, max outstanding ops per requester (1..FMAC_DELAY+1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
REQ_A_TDATA  in  NREQ*32  operand A, requester k in bits [32k+31:32k]
REQ_B_TDATA  in  NREQ*32  operand B, same packing
REQ_C_TDATA  in  NREQ*32  accumulator C, same packing
REQ_TVALID  in  NREQ  per-requester op valid
REQ_TREADY  out  NREQ  per-requester accept, one-hot or zero
RSP_TDATA  out  32  result (shared bus)
RSP_TVALID  out  NREQ  one-hot result strobe; no back-pressure
FMAC_A_TDATA  out  32  to FMAC A
FMAC_B_TDATA  out  32  to FMAC B
FMAC_C_TDATA  out  32  to FMAC C
FMAC_TVALID  out  1  drives the FMAC A/B/C TVALID together
FMAC_OUT_TDATA  in  32  FMAC result
FMAC_OUT_TVALID  in  1  FMAC result valid
drain_req  in  1  stop granting and empty the pipeline
drained  out  1  high while in ST_DRAINED
tag_err  out  1  sticky error: result arrived with no matching tag

Behaviour:
- Reset (async assert; release on a clk edge): all outputs 0; rr_ptr=0; tag pipe empty; outstanding counts 0; state ST_RUN.
- Eligible requester k: REQ_TVALID[k] && cnt[k]<MAX_OUT && state==ST_RUN.
- Grant: combinationally, the first eligible k searching from rr_ptr upward with wrap; REQ_TREADY[k]=1 for that k only.
- On grant, rr_ptr <= (k+1) mod NREQ. If nothing is granted, rr_ptr holds.
- Issue stage is registered. The cycle after a handshake, FMAC_TVALID=1 and FMAC_A/B/C carry the granted operands. Otherwise FMAC_TVALID=0 and the data regs hold their values.
- Tag pipe:
  - FMAC_DELAY entries of {valid, idx}, shifted every cycle.
  - Entry 0 is loaded with {FMAC_TVALID, grant idx}.
  - The last entry aligns with FMAC_OUT_TVALID.
- Response (combinational from FMAC outputs):
  - RSP_TDATA = FMAC_OUT_TDATA.
  - RSP_TVALID[idx] = FMAC_OUT_TVALID && tail.valid.
  - Total latency, requester handshake to RSP_TVALID: FMAC_DELAY+1 cycles.
- tag_err set if FMAC_OUT_TVALID && !tail.valid; cleared only by rst. The result is dropped.
- Outstanding counters:
  - cnt[k] +1 on grant to k, −1 on response to k.
  - Both in the same cycle: net unchanged.
  - Width $clog2(MAX_OUT+1).
  - Never exceeds MAX_OUT, since eligibility blocks the grant.
- State machine:
  - ST_RUN: on drain_req go to ST_DRAIN; no grant is issued in that same cycle.
  - ST_DRAIN: no grants. When the issue reg and all tag entries are invalid, go to ST_DRAINED.
  - ST_DRAINED: drained=1. When drain_req falls, go to ST_RUN and resume at the current rr_ptr.
  - drain_req deasserted while in ST_DRAIN: still complete to ST_DRAINED, then return to ST_RUN next cycle.
- Single requester continuously valid with MAX_OUT ≥ FMAC_DELAY+1: one issue per cycle, full throughput.

Optional Feature:
- Macro: FMAC_ARBITER_STATS_EN.
- When defined, adds ports:
  - stat_clr (in, 1)
  - stat_busy (out, 32): cycles with FMAC_TVALID=1
  - stat_stall (out, 32): cycles with any REQ_TVALID but no grant
- Both counters saturate at 32'hFFFFFFFF, reset to 0, and are cleared synchronously by stat_clr (clear wins over increment).
- Without the macro: no ports, no counters, behaviour otherwise identical.

Test Plan:
- Reset then all 4 requesters valid continuously, FMAC model echoing A after 8 cycles -> grants rotate 0,1,2,3,0…; each RSP_TVALID[k] arrives exactly 9 cycles after its handshake with the correct echoed data.
- Requester 2 alone valid, MAX_OUT=2 -> two grants, then REQ_TREADY[2] low until the first response; then it resumes, at most 2 in flight.
- drain_req pulsed mid-stream with 5 ops in flight -> no grants after assertion; drained=1 once the 5th result returns; drain_req low -> grants resume from rr_ptr.
- Inject FMAC_OUT_TVALID with an empty tag pipe -> tag_err=1, no RSP_TVALID; it stays 1 until rst.
- Assert rst asynchronously mid-operation -> all outputs 0 immediately; counts cleared; post-reset first grant goes to requester 0.
- With FMAC_ARBITER_STATS_EN: 10 grants, 3 blocked cycles -> stat_busy=10, stat_stall=3; stat_clr -> both 0.
